seq_adder: RTL
==============

SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 Parameter DIGIT, default 4, bits added per clock; WIDTH % DIGIT == 0 SHALL be enforced by an elaboration-time check; NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a, b  input  WIDTH  unsigned operands.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  registered sum.
REQ-012 cout  output  1  registered carry-out.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid&in_ready, a, b, cin (and approx_k if configured) SHALL be captured, digit counter cleared, and the state SHALL become BUSY.
REQ-015 BUSY: each cycle adds the low DIGIT bits of the operand shift registers plus the carry register, shifts operands right by DIGIT, shifts the digit sum into sum from the MSB end, and updates the carry register.
REQ-016 After NDIG BUSY cycles the state SHALL become DONE; out_valid SHALL rise exactly NDIG rising edges after the accepting edge.
REQ-017 Result: {cout,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1) (exact mode).
REQ-018 DONE: sum/cout SHALL stay stable while out_valid=1 and out_ready=0; on out_ready=1 the state SHALL return to IDLE next edge.
REQ-019 in_valid during BUSY/DONE SHALL be ignored; operand inputs SHALL not affect an operation in flight.
REQ-020 NDIG=1 SHALL be legal (single BUSY cycle).

Reset
REQ-021 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, sum=0, cout=0, carry and counter 0, independent of clk.
REQ-022 Reset during BUSY or DONE SHALL abandon the operation; no result SHALL be presented.

Configuration
REQ-023 Macro SEQ_ADDER_APPROX_EN: when defined, input approx_k (width clog2(NDIG+1)) exists, sampled at accept; for digit index i < approx_k the digit sum SHALL be bitwise a|b and its carry-out SHALL be 0, cin SHALL be ignored if approx_k>=1; digits >= approx_k are exact; approx_k=0 SHALL equal exact mode; approx_k>NDIG SHALL saturate to NDIG.
REQ-024 Without SEQ_ADDER_APPROX_EN, approx_k port SHALL be absent and behaviour SHALL be exact (REQ-017).

Structure
REQ-025 Package seq_adder_pkg SHALL hold the state enum type and the NDIG/counter-width helper function.
REQ-026 One sub-module seq_adder_digit SHALL implement the combinational DIGIT-bit ripple add (and the OR path under SEQ_ADDER_APPROX_EN); the top holds FSM, counter, and shift registers.

Verification (WIDTH=16, DIGIT=4)
REQ-027 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid 4 edges after accept.
REQ-028 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-029 out_ready held 0 for 10 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-030 rst_n pulsed low on 2nd BUSY cycle -> out_valid=0, sum=0 immediately; next op 0x0003+0x0004 -> 0x0007.
REQ-031 SEQ_ADDER_APPROX_EN, approx_k=1, a=0x000F, b=0x0001, cin=1 -> sum=0x000F, cout=0; approx_k=0 same operands -> sum=0x0011.
REQ-032 Back-to-back: in_valid held high with out_ready=1 -> one accept per NDIG+2 cycles, results in order.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   // Counter must index digits 0..n-1 and never collapse to zero bits.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_adder_digit.sv
// One DIGIT-bit ripple-carry slice; with SEQ_ADDER_APPROX_EN an OR path
// replaces the add for approximated digits.
module seq_adder_digit #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
`ifdef SEQ_ADDER_APPROX_EN
   input  logic             approx,
`endif
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[DIGIT];
`ifdef SEQ_ADDER_APPROX_EN
      // Approximated digits neither consume nor produce a carry.
      if (approx) begin
         s  = a | b;
         co = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder: DIGIT bits per clock, valid/ready on both sides.
// Optional approximate low digits under SEQ_ADDER_APPROX_EN.
module seq_adder
   import seq_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SEQ_ADDER_APPROX_EN
   input  logic [$clog2(WIDTH/DIGIT+1)-1:0] approx_k,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
   localparam int unsigned CW   = cnt_width(NDIG);

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("seq_adder: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, sum_q, sum_shift;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, in_ready_q, out_valid_q;
   logic [DIGIT-1:0] dsum;
   logic             dco;
   logic             last_c;

   assign last_c = (cnt_q == CW'(NDIG - 1));

`ifdef SEQ_ADDER_APPROX_EN
   localparam int unsigned KW = $clog2(NDIG + 1);
   logic [KW-1:0] k_q;
   logic          approx_c;
   assign approx_c = (KW'(cnt_q) < k_q);
`endif

   seq_adder_digit #(.DIGIT(DIGIT)) u_digit (
      .a      (a_q[DIGIT-1:0]),
      .b      (b_q[DIGIT-1:0]),
      .ci     (carry_q),
`ifdef SEQ_ADDER_APPROX_EN
      .approx (approx_c),
`endif
      .s      (dsum),
      .co     (dco)
   );

   // New digit enters at the MSB end so the result is aligned after NDIG steps.
   generate
      if (NDIG == 1) begin : g_one
         assign sum_shift = dsum;
      end else begin : g_many
         assign sum_shift = {dsum, sum_q[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         in_ready_q  <= (state_nxt == IDLE);
         out_valid_q <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last_c)    state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Operand capture and one digit step per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SEQ_ADDER_APPROX_EN
         k_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
`ifdef SEQ_ADDER_APPROX_EN
                  k_q     <= (approx_k > KW'(NDIG)) ? KW'(NDIG) : approx_k;
`endif
               end
            end
            BUSY: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               sum_q   <= sum_shift;
               carry_q <= dco;
               cnt_q   <= cnt_q + CW'(1);
               if (last_c) cout_q <= dco;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
